// File: rtl/pipeline_stage_skid.sv
// ============================================================================
// pipeline_stage_skid : inter-stage pipeline register with optional skid entry
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stage_skid #(
  parameter int unsigned             DATA_W    = 68,
  parameter logic [DATA_W-1:0]       NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                      SKID_EN   = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  output logic              skid_full,
  output logic [15:0]       bubble_cnt,
  input  logic              bubble_clr
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [15:0]       bubble_q, bubble_d;
  logic              push, pop;

  assign out_valid  = (state_q != S_EMPTY);
  assign skid_full  = (state_q == S_FULL);
  assign out_data   = main_q;
  assign bubble_cnt = bubble_q;

  // With the skid entry, in_ready is a pure state decode so the upstream
  // stage never sees a combinational path from out_ready/hold.
  generate
    if (SKID_EN) begin : g_skid_ready
      assign in_ready = (state_q != S_FULL);
    end else begin : g_comb_ready
      assign in_ready = (state_q == S_EMPTY) | (out_ready & ~hold);
    end
  endgenerate

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~hold & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = S_EMPTY;
            main_d  = NOP_VALUE;
          end else if (push && SKID_EN) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (bubble_clr) begin
      bubble_d = 16'd0;
    end else if (out_ready && !out_valid && !hold && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      bubble_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_skid.sv
// ============================================================================
// tb_pipeline_stage_skid : directed bench for both skid and non-skid variants
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stage_skid;

  localparam int DW = 68;

  logic          CLK = 1'b0;
  logic          nRST;

  logic          in_valid, out_ready, flush, hold, bubble_clr;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, skid_full;
  logic [DW-1:0] out_data;
  logic [15:0]   bubble_cnt;

  logic          v0_in_valid, v0_out_ready, v0_flush, v0_hold, v0_bubble_clr;
  logic [DW-1:0] v0_in_data;
  logic          v0_in_ready, v0_out_valid, v0_skid_full;
  logic [DW-1:0] v0_out_data;
  logic [15:0]   v0_bubble_cnt;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  pipeline_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .hold(hold), .skid_full(skid_full),
    .bubble_cnt(bubble_cnt), .bubble_clr(bubble_clr)
  );

  pipeline_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0)) dut0 (
    .CLK(CLK), .nRST(nRST),
    .in_valid(v0_in_valid), .in_ready(v0_in_ready), .in_data(v0_in_data),
    .out_valid(v0_out_valid), .out_ready(v0_out_ready), .out_data(v0_out_data),
    .flush(v0_flush), .hold(v0_hold), .skid_full(v0_skid_full),
    .bubble_cnt(v0_bubble_cnt), .bubble_clr(v0_bubble_clr)
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          hld;
    logic          fl;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
    logic          sf;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic hld, logic fl,
                              logic ov, logic [DW-1:0] od, logic ir, logic sf);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.hld = hld; v.fl = fl;
    v.ov = ov; v.od = od; v.ir = ir; v.sf = sf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] bub_exp;
  logic        prev_ov;

  initial begin
    // Stream, skid fill/drain, flush, hold, hold-with-skid-push
    vecs[0]  = mk(1, 68'h1, 1, 0, 0,  1, 68'h1, 1, 0);
    vecs[1]  = mk(1, 68'h2, 1, 0, 0,  1, 68'h2, 1, 0);
    vecs[2]  = mk(1, 68'h3, 1, 0, 0,  1, 68'h3, 1, 0);
    vecs[3]  = mk(0, 68'h0, 1, 0, 0,  0, 68'h0, 1, 0);
    vecs[4]  = mk(1, 68'hA, 1, 0, 0,  1, 68'hA, 1, 0);
    vecs[5]  = mk(1, 68'hB, 0, 0, 0,  1, 68'hA, 0, 1);
    vecs[6]  = mk(1, 68'hC, 0, 0, 0,  1, 68'hA, 0, 1);
    vecs[7]  = mk(0, 68'h0, 1, 0, 0,  1, 68'hB, 1, 0);
    vecs[8]  = mk(0, 68'h0, 1, 0, 0,  0, 68'h0, 1, 0);
    vecs[9]  = mk(1, 68'hA, 0, 0, 0,  1, 68'hA, 1, 0);
    vecs[10] = mk(1, 68'hB, 0, 0, 0,  1, 68'hA, 0, 1);
    vecs[11] = mk(1, 68'hC, 1, 0, 1,  0, 68'h0, 1, 0);
    vecs[12] = mk(0, 68'h0, 1, 0, 0,  0, 68'h0, 1, 0);
    vecs[13] = mk(1, 68'h5, 1, 0, 0,  1, 68'h5, 1, 0);
    vecs[14] = mk(0, 68'h0, 1, 1, 0,  1, 68'h5, 1, 0);
    vecs[15] = mk(0, 68'h0, 1, 1, 0,  1, 68'h5, 1, 0);
    vecs[16] = mk(0, 68'h0, 1, 1, 0,  1, 68'h5, 1, 0);
    vecs[17] = mk(0, 68'h0, 1, 0, 0,  0, 68'h0, 1, 0);
    vecs[18] = mk(1, 68'h6, 1, 0, 0,  1, 68'h6, 1, 0);
    vecs[19] = mk(1, 68'h7, 1, 1, 0,  1, 68'h6, 0, 1);
    vecs[20] = mk(0, 68'h0, 1, 0, 0,  1, 68'h7, 1, 0);
    vecs[21] = mk(0, 68'h0, 1, 0, 0,  0, 68'h0, 1, 0);

    nRST = 1'b0;
    in_valid = 0; in_data = '0; out_ready = 0; flush = 0; hold = 0; bubble_clr = 0;
    v0_in_valid = 0; v0_in_data = '0; v0_out_ready = 0; v0_flush = 0; v0_hold = 0;
    v0_bubble_clr = 0;
    tick();
    tick();
    chk("rst_out_valid", {67'd0, out_valid}, 68'd0);
    chk("rst_skid_full", {67'd0, skid_full}, 68'd0);
    chk("rst_bubble",    {52'd0, bubble_cnt}, 68'd0);
    chk("rst_out_data",  out_data, 68'd0);

    nRST = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", {67'd0, in_ready}, 68'd1);
    tick();
    chk("rel_bubble1", {52'd0, bubble_cnt}, 68'd1);
    tick();
    chk("rel_bubble2", {52'd0, bubble_cnt}, 68'd2);
    chk("rel_out_valid", {67'd0, out_valid}, 68'd0);
    bubble_clr = 1'b1;
    tick();
    bubble_clr = 1'b0;
    chk("clr_bubble", {52'd0, bubble_cnt}, 68'd0);

    bub_exp = 16'd0;
    prev_ov = 1'b0;
    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      hold = vecs[i].hld; flush = vecs[i].fl;
      if (vecs[i].ordy && !prev_ov && !vecs[i].hld) bub_exp = bub_exp + 16'd1;
      tick();
      chk($sformatf("v%0d_out_valid", i), {67'd0, out_valid}, {67'd0, vecs[i].ov});
      chk($sformatf("v%0d_out_data", i),  out_data, vecs[i].od);
      chk($sformatf("v%0d_in_ready", i),  {67'd0, in_ready}, {67'd0, vecs[i].ir});
      chk($sformatf("v%0d_skid_full", i), {67'd0, skid_full}, {67'd0, vecs[i].sf});
      chk($sformatf("v%0d_bubble", i),    {52'd0, bubble_cnt}, {52'd0, bub_exp});
      prev_ov = vecs[i].ov;
    end
    in_valid = 0; hold = 0; flush = 0;

    // Non-skid variant: in_ready follows out_ready/hold combinationally
    v0_in_valid = 1; v0_in_data = 68'h9; v0_out_ready = 0;
    tick();
    v0_in_valid = 0;
    #1;
    chk("ns_out_data", v0_out_data, 68'h9);
    chk("ns_ready_low", {67'd0, v0_in_ready}, 68'd0);
    v0_out_ready = 1;
    #1;
    chk("ns_ready_high", {67'd0, v0_in_ready}, 68'd1);
    v0_hold = 1;
    #1;
    chk("ns_ready_hold", {67'd0, v0_in_ready}, 68'd0);
    v0_hold = 0;
    v0_in_valid = 1; v0_in_data = 68'h1A;
    tick();
    v0_in_valid = 0;
    chk("ns_pushpop_data", v0_out_data, 68'h1A);
    chk("ns_pushpop_valid", {67'd0, v0_out_valid}, 68'd1);
    chk("ns_skid_full", {67'd0, v0_skid_full}, 68'd0);
    tick();
    chk("ns_drain_valid", {67'd0, v0_out_valid}, 68'd0);

    // Asynchronous reset mid-operation
    in_valid = 1; in_data = 68'h44; out_ready = 0;
    tick();
    in_data = 68'h55;
    tick();
    in_valid = 0;
    chk("pre_rst_full", {67'd0, skid_full}, 68'd1);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_valid", {67'd0, out_valid}, 68'd0);
    chk("async_rst_skid",  {67'd0, skid_full}, 68'd0);
    chk("async_rst_data",  out_data, 68'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Saturation of the bubble counter
    out_ready = 1; bubble_clr = 1;
    tick();
    bubble_clr = 0;
    for (int i = 0; i < 65534; i++) tick();
    chk("bubble_fffe", {52'd0, bubble_cnt}, 68'hFFFE);
    tick();
    chk("bubble_ffff", {52'd0, bubble_cnt}, 68'hFFFF);
    tick();
    tick();
    chk("bubble_sat", {52'd0, bubble_cnt}, 68'hFFFF);
    bubble_clr = 1;
    tick();
    bubble_clr = 0;
    chk("bubble_clr0", {52'd0, bubble_cnt}, 68'd0);
    tick();
    chk("bubble_after_clr", {52'd0, bubble_cnt}, 68'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
